// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared gate mode and BIST state encodings
// Contents: MODE_* gate function codes, state_e FSM encoding, mode_legal() helper.
package gate_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Codes 6 and 7 are reserved.
    function automatic logic mode_legal(input logic [2:0] m);
        return (m <= MODE_XNOR);
    endfunction

endpackage

// File: rtl/gate_ref.sv
// rtl/gate_ref.sv - combinational N_IN-input reference gate selected by mode
// Ports: mode_i (gate function), a_i (N_IN inputs), y_o (reduction result; 0 for reserved modes).
module gate_ref
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      mode_i,
    input  logic [N_IN-1:0] a_i,
    output logic            y_o
);

    always_comb begin
        y_o = 1'b0;
        case (mode_i)
            MODE_AND:  y_o = &a_i;
            MODE_OR:   y_o = |a_i;
            MODE_XOR:  y_o = ^a_i;
            MODE_NAND: y_o = ~&a_i;
            MODE_NOR:  y_o = ~|a_i;
            MODE_XNOR: y_o = ~^a_i;
            default:   y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - exhaustive sweep BIST for an N_IN-input logic gate
// Ports: clk, rst_n (async active-low), start/mode (sweep request), stim/dut_y (gate under test),
//        busy/done/pass (status), err_cnt/fail_vec/fail_vld (mismatch results).
module gate_bist
    import gate_pkg::*;
#(
    parameter int N_IN    = 2,
    parameter int LATENCY = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mode,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_vld
);

    localparam logic [1:0] DRAIN_LAST = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

    state_e          state_q;
    logic [N_IN-1:0] vec_q;
    logic [2:0]      mode_q;
    logic            bad_mode_q;
    logic [1:0]      drain_q;
    logic [N_IN:0]   err_q;
    logic [N_IN-1:0] fail_vec_q;
    logic            fail_vld_q;

    logic            in_sweep;
    logic            exp_now;
    logic            exp_dly;
    logic            vld_dly;
    logic [N_IN-1:0] stim_dly;
    logic            mismatch;

    assign in_sweep = (state_q == ST_SWEEP);
    assign stim     = in_sweep ? vec_q : '0;
    assign busy     = in_sweep || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign pass     = done && !bad_mode_q && (err_q == '0);
    assign err_cnt  = err_q;
    assign fail_vec = fail_vec_q;
    assign fail_vld = fail_vld_q;

    gate_ref #(.N_IN(N_IN)) u_ref (
        .mode_i (mode_q),
        .a_i    (vec_q),
        .y_o    (exp_now)
    );

    // Expected value, valid and stimulus copy travel together so that the
    // compare lines up with the gate response LATENCY cycles later.
    generate
        if (LATENCY == 0) begin : g_nodly
            assign exp_dly  = exp_now;
            assign vld_dly  = in_sweep;
            assign stim_dly = stim;
        end else begin : g_dly
            logic            exp_pipe_q  [LATENCY];
            logic            vld_pipe_q  [LATENCY];
            logic [N_IN-1:0] stim_pipe_q [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        exp_pipe_q[i]  <= 1'b0;
                        vld_pipe_q[i]  <= 1'b0;
                        stim_pipe_q[i] <= '0;
                    end
                end else begin
                    exp_pipe_q[0]  <= exp_now;
                    vld_pipe_q[0]  <= in_sweep;
                    stim_pipe_q[0] <= stim;
                    for (int i = 1; i < LATENCY; i++) begin
                        exp_pipe_q[i]  <= exp_pipe_q[i-1];
                        vld_pipe_q[i]  <= vld_pipe_q[i-1];
                        stim_pipe_q[i] <= stim_pipe_q[i-1];
                    end
                end
            end

            assign exp_dly  = exp_pipe_q[LATENCY-1];
            assign vld_dly  = vld_pipe_q[LATENCY-1];
            assign stim_dly = stim_pipe_q[LATENCY-1];
        end
    endgenerate

    assign mismatch = vld_dly && (dut_y != exp_dly);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            mode_q     <= MODE_AND;
            bad_mode_q <= 1'b0;
            drain_q    <= 2'd0;
            err_q      <= '0;
            fail_vec_q <= '0;
            fail_vld_q <= 1'b0;
        end else begin
            // Valid compares only occur in SWEEP/DRAIN, so this never
            // collides with the clearing done by an accepted start below.
            if (mismatch) begin
                err_q <= err_q + 1'b1;
                if (!fail_vld_q) begin
                    fail_vec_q <= stim_dly;
                    fail_vld_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q     <= mode;
                        err_q      <= '0;
                        fail_vec_q <= '0;
                        fail_vld_q <= 1'b0;
                        vec_q      <= '0;
                        if (mode_legal(mode)) begin
                            bad_mode_q <= 1'b0;
                            state_q    <= ST_SWEEP;
                        end else begin
                            bad_mode_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_SWEEP: begin
                    vec_q <= vec_q + 1'b1;
                    if (vec_q == '1) begin
                        drain_q <= 2'd0;
                        state_q <= (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - self-checking bench for gate_bist
module tb_gate_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Independent gate model
    function automatic logic ref_gate(input logic [2:0] m, input logic [7:0] v, input int n);
        logic a, o, x;
        a = 1'b1; o = 1'b0; x = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a & v[i]; o = o | v[i]; x = x ^ v[i];
        end
        case (m)
            3'd0: return a;
            3'd1: return o;
            3'd2: return x;
            3'd3: return ~a;
            3'd4: return ~o;
            3'd5: return ~x;
            default: return 1'b0;
        endcase
    endfunction

    // flt: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 always inverted, 4 inverted at vector k only
    function automatic logic apply_fault(input logic good, input int flt, input int k, input int v);
        case (flt)
            1: return 1'b1;
            2: return 1'b0;
            3: return ~good;
            4: return (v == k) ? ~good : good;
            default: return good;
        endcase
    endfunction

    // Instance A: N_IN=2, LATENCY=0
    logic       start_a, y_a, busy_a, done_a, pass_a, fvld_a;
    logic [2:0] mode_a, mm_a, err_a;
    logic [1:0] stim_a, fv_a;
    int         flt_a, fk_a;
    always_comb y_a = apply_fault(ref_gate(mm_a, 8'(stim_a), 2), flt_a, fk_a, int'(stim_a));

    gate_bist #(.N_IN(2), .LATENCY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .stim(stim_a), .dut_y(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_vec(fv_a), .fail_vld(fvld_a)
    );

    // Instance B: N_IN=3, LATENCY=2 (gate response delayed by two flops)
    logic       start_b, y_b, busy_b, done_b, pass_b, fvld_b;
    logic [2:0] mode_b, mm_b, stim_b, fv_b, sb1, sb2;
    logic [3:0] err_b;
    int         flt_b, fk_b;
    always @(posedge clk) begin
        sb1 <= stim_b;
        sb2 <= sb1;
    end
    always_comb y_b = apply_fault(ref_gate(mm_b, 8'(sb2), 3), flt_b, fk_b, int'(sb2));

    gate_bist #(.N_IN(3), .LATENCY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .stim(stim_b), .dut_y(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_vec(fv_b), .fail_vld(fvld_b)
    );

    // Instance C: N_IN=4, LATENCY=0
    logic       start_c, y_c, busy_c, done_c, pass_c, fvld_c;
    logic [2:0] mode_c, mm_c;
    logic [3:0] stim_c, fv_c;
    logic [4:0] err_c;
    int         flt_c, fk_c;
    always_comb y_c = apply_fault(ref_gate(mm_c, 8'(stim_c), 4), flt_c, fk_c, int'(stim_c));

    gate_bist #(.N_IN(4), .LATENCY(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .mode(mode_c), .stim(stim_c), .dut_y(y_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c), .fail_vec(fv_c), .fail_vld(fvld_c)
    );

    typedef struct {
        logic [2:0] mode;
        int         flt;
        int         fk;
        logic [2:0] err;
        logic [1:0] fv;
        logic       fvld;
        logic       pass;
    } vec_t;

    vec_t tbl[10];

    task automatic run_a(input int idx);
        @(negedge clk);
        start_a = 1'b1; mode_a = tbl[idx].mode; mm_a = tbl[idx].mode;
        flt_a = tbl[idx].flt; fk_a = tbl[idx].fk;
        @(negedge clk);
        start_a = 1'b0;
        chk($sformatf("a%0d_done_after_start", idx), done_a, (tbl[idx].mode > 3'd5) ? 1 : 0);
        for (int i = 0; i < 50 && !done_a; i++) @(negedge clk);
        chk($sformatf("a%0d_done", idx), done_a, 1);
        chk($sformatf("a%0d_err_cnt", idx), err_a, tbl[idx].err);
        chk($sformatf("a%0d_fail_vec", idx), fv_a, tbl[idx].fv);
        chk($sformatf("a%0d_fail_vld", idx), fvld_a, tbl[idx].fvld);
        chk($sformatf("a%0d_pass", idx), pass_a, tbl[idx].pass);
    endtask

    int  nb;
    logic stim_ok, seen_done;

    initial begin
        //            mode   flt fk err   fv    vld   pass
        tbl[0] = '{3'd1, 0, 0, 3'd0, 2'd0, 1'b0, 1'b1};
        tbl[1] = '{3'd0, 1, 0, 3'd3, 2'd0, 1'b1, 1'b0};
        tbl[2] = '{3'd3, 2, 0, 3'd3, 2'd0, 1'b1, 1'b0};
        tbl[3] = '{3'd2, 2, 0, 3'd2, 2'd1, 1'b1, 1'b0};
        tbl[4] = '{3'd4, 1, 0, 3'd3, 2'd1, 1'b1, 1'b0};
        tbl[5] = '{3'd5, 3, 0, 3'd4, 2'd0, 1'b1, 1'b0};
        tbl[6] = '{3'd2, 4, 2, 3'd1, 2'd2, 1'b1, 1'b0};
        tbl[7] = '{3'd1, 4, 3, 3'd1, 2'd3, 1'b1, 1'b0};
        tbl[8] = '{3'd6, 0, 0, 3'd0, 2'd0, 1'b0, 1'b0};
        tbl[9] = '{3'd0, 0, 0, 3'd0, 2'd0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start_a = 0; mode_a = 0; mm_a = 0; flt_a = 0; fk_a = 0;
        start_b = 0; mode_b = 0; mm_b = 0; flt_b = 0; fk_b = 0;
        start_c = 0; mode_c = 0; mm_c = 0; flt_c = 0; fk_c = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_stim", stim_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fvld", fvld_a, 0);
        rst_n = 1'b1;

        // OR sweep, stim 0..3 on consecutive cycles
        @(negedge clk);
        start_a = 1'b1; mode_a = 3'd1; mm_a = 3'd1; flt_a = 0;
        @(negedge clk);
        start_a = 1'b0;
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("or_stim%0d", v), stim_a, v);
            chk($sformatf("or_busy%0d", v), busy_a, 1);
            @(negedge clk);
        end
        chk("or_done", done_a, 1);
        chk("or_pass", pass_a, 1);
        chk("or_err", err_a, 0);
        chk("or_stim_done", stim_a, 0);

        for (int r = 0; r < 10; r++) run_a(r);

        // Reserved mode: DONE one cycle after start, stim stays 0
        @(negedge clk);
        start_a = 1'b1; mode_a = 3'd7; mm_a = 3'd7;
        @(negedge clk);
        start_a = 1'b0;
        chk("rsv_done", done_a, 1);
        chk("rsv_pass", pass_a, 0);
        chk("rsv_err", err_a, 0);
        chk("rsv_stim", stim_a, 0);
        chk("rsv_busy", busy_a, 0);
        @(negedge clk);
        chk("rsv_stim_later", stim_a, 0);

        // N_IN=4 NOR with a single inverted response at vector 9
        @(negedge clk);
        start_c = 1'b1; mode_c = 3'd4; mm_c = 3'd4; flt_c = 4; fk_c = 9;
        @(negedge clk);
        start_c = 1'b0;
        for (int i = 0; i < 50 && !done_c; i++) @(negedge clk);
        chk("c_done", done_c, 1);
        chk("c_err", err_c, 1);
        chk("c_fail_vec", fv_c, 9);
        chk("c_fail_vld", fvld_c, 1);
        chk("c_pass", pass_c, 0);

        // N_IN=3, LATENCY=2 XOR: 8 sweep + 2 drain cycles
        @(negedge clk);
        start_b = 1'b1; mode_b = 3'd2; mm_b = 3'd2; flt_b = 0;
        @(negedge clk);
        start_b = 1'b0;
        nb = 0; stim_ok = 1'b1;
        for (int i = 0; i < 40 && busy_b; i++) begin
            if ((nb < 8) ? (stim_b != 3'(nb)) : (stim_b != 3'd0)) stim_ok = 1'b0;
            nb++;
            @(negedge clk);
        end
        chk("b_busy_cycles", nb, 10);
        chk("b_stim_order", stim_ok, 1);
        chk("b_done", done_b, 1);
        chk("b_pass", pass_b, 1);
        chk("b_err", err_b, 0);

        // Restart from DONE, ignored start mid-sweep, reset at vector 5
        @(negedge clk);
        start_b = 1'b1; mode_b = 3'd2; mm_b = 3'd2; flt_b = 1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b2_done_cleared", done_b, 0);
        chk("b2_stim0", stim_b, 0);
        @(negedge clk);
        chk("b2_stim1", stim_b, 1);
        start_b = 1'b1; mode_b = 3'd0;
        @(negedge clk);
        start_b = 1'b0;
        for (int v = 2; v < 5; v++) begin
            chk($sformatf("b2_stim%0d", v), stim_b, v);
            @(negedge clk);
        end
        chk("b2_stim5", stim_b, 5);
        chk("b2_err_pre_rst", err_b, 1);
        chk("b2_fvld_pre_rst", fvld_b, 1);
        rst_n = 1'b0;
        #1;
        chk("b2_rst_stim", stim_b, 0);
        chk("b2_rst_busy", busy_b, 0);
        chk("b2_rst_done", done_b, 0);
        chk("b2_rst_pass", pass_b, 0);
        chk("b2_rst_err", err_b, 0);
        chk("b2_rst_fvec", fv_b, 0);
        chk("b2_rst_fvld", fvld_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_b || busy_b) seen_done = 1'b1;
        end
        chk("b2_no_done_after_rst", seen_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
